// File: rtl/matrix_row_packer.sv
// ---------------------------------------------------------------------------
// matrix_row_packer
//
// Upstream feeder of the 4x4 byte-matrix transposer. It packs an incoming
// byte stream into 32-bit row words, byte 0 of each word in [7:0]. Every
// matrix leaves this block as exactly four row words, so the transposer's
// free-running word counter stays frame-aligned:
//   - a short frame (s_last before byte 15) has its open word filled with
//     PAD_BYTE and is then topped up with all-pad words up to row word 3;
//   - a long frame (byte 15 arrives without s_last) is closed anyway, and the
//     next byte starts a new matrix.
// Both cases raise a sticky error bit.
//
// Ports:
//   clk      in   1   clock, all state updates on the rising edge
//   rst_n    in   1   synchronous active-low reset
//   s_data   in   8   input byte
//   s_valid  in   1   input byte valid
//   s_last   in   1   final byte of a matrix (nominally byte 15)
//   s_ready  out  1   block accepts s_data this cycle
//   m_data   out  32  packed row word (registered)
//   m_valid  out  1   row word valid
//   m_ready  in   1   transposer ready
//   m_last   out  1   high with row word 3 of a matrix
//   err      out  2   sticky: [0] short frame, [1] long frame
//   err_clr  in   1   clears err on the next edge (new errors take priority)
//
// Parameters:
//   PAD_BYTE      fill value for bytes missing from a short frame
// ---------------------------------------------------------------------------
module matrix_row_packer #(
  parameter logic [7:0] PAD_BYTE = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  output logic [31:0] m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        m_last,
  output logic [1:0]  err,
  input  logic        err_clr
);

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_PAD  = 1'b1
  } state_t;

  state_t      state_reg;
  logic [1:0]  byte_cnt_reg;   // byte position within the current word
  logic [1:0]  word_cnt_reg;   // word index within the current matrix
  logic [31:0] m_data_reg;
  logic        m_valid_reg;
  logic        m_last_reg;
  logic [1:0]  err_reg;

  logic        slot_free;
  logic        word_end;
  logic        s_ready_int;
  logic        s_fire;
  logic        m_fire;
  logic        load_fill;
  logic        frame_end_pos;
  logic        short_err;
  logic        long_err;
  logic [31:0] fill_word;

  // The output register can take a new word when it is empty or being
  // drained this very cycle, which allows back-to-back words.
  assign slot_free = !m_valid_reg | m_ready;
  assign m_fire    = m_valid_reg & m_ready;

  // A byte closes the current word when it fills lane 3 or carries s_last.
  assign word_end  = (byte_cnt_reg == 2'd3) | s_last;

  // Only word-closing bytes need the output slot, so only those bytes make
  // s_ready depend on m_ready. Nothing is accepted while padding.
  always_comb begin
    s_ready_int = 1'b0;
    if (state_reg == ST_FILL) begin
      s_ready_int = word_end ? slot_free : 1'b1;
    end
  end

  assign s_fire    = s_valid & s_ready_int;
  assign load_fill = s_fire & word_end;

  // Position (3,3) is byte 15: the only legal place for s_last.
  assign frame_end_pos = (word_cnt_reg == 2'd3) && (byte_cnt_reg == 2'd3);
  assign short_err     = s_fire & s_last & !frame_end_pos;
  assign long_err      = s_fire & !s_last & frame_end_pos;

  // Byte lanes. Lanes 0..2 hold bytes that arrived earlier in the word;
  // lane 3 is only ever written by the closing byte, so it needs no storage.
  // For the word being closed, each lane takes its held byte if already
  // received, the incoming byte if it is this lane's turn, else PAD_BYTE.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      if (gi < 3) begin : g_held
        logic [7:0] lane_reg;

        always_ff @(posedge clk) begin
          if (!rst_n) begin
            lane_reg <= 8'h00;
          end else if (s_fire && !word_end && (byte_cnt_reg == 2'(gi))) begin
            lane_reg <= s_data;
          end
        end

        assign fill_word[gi*8 +: 8] =
          (byte_cnt_reg > 2'(gi))  ? lane_reg :
          (byte_cnt_reg == 2'(gi)) ? s_data   :
                                     PAD_BYTE;
      end else begin : g_top
        assign fill_word[gi*8 +: 8] =
          (byte_cnt_reg == 2'(gi)) ? s_data : PAD_BYTE;
      end
    end
  endgenerate

  // Control FSM and output register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= ST_FILL;
      byte_cnt_reg <= 2'd0;
      word_cnt_reg <= 2'd0;
      m_data_reg   <= 32'h0;
      m_valid_reg  <= 1'b0;
      m_last_reg   <= 1'b0;
    end else begin
      case (state_reg)
        ST_FILL: begin
          if (load_fill) begin
            // Closing byte: load the word. word_cnt advances on load, not on
            // m_fire, so it always tracks what the transposer will receive.
            m_data_reg   <= fill_word;
            m_valid_reg  <= 1'b1;
            m_last_reg   <= (word_cnt_reg == 2'd3);
            word_cnt_reg <= word_cnt_reg + 2'd1;
            byte_cnt_reg <= 2'd0;
            // A short frame that ends before row word 3 still owes the
            // transposer whole pad words. A long frame needs nothing extra:
            // the word at (3,3) already carries m_last.
            if (short_err && (word_cnt_reg != 2'd3)) begin
              state_reg <= ST_PAD;
            end
          end else begin
            if (s_fire) begin
              byte_cnt_reg <= byte_cnt_reg + 2'd1;
            end
            if (m_fire) begin
              m_valid_reg <= 1'b0;
            end
          end
        end

        ST_PAD: begin
          // m_valid never needs clearing here: every free slot is refilled.
          if (slot_free) begin
            m_data_reg   <= {4{PAD_BYTE}};
            m_valid_reg  <= 1'b1;
            m_last_reg   <= (word_cnt_reg == 2'd3);
            word_cnt_reg <= word_cnt_reg + 2'd1;
            if (word_cnt_reg == 2'd3) begin
              state_reg <= ST_FILL;
            end
          end
        end

        default: begin
          state_reg <= ST_FILL;
        end
      endcase
    end
  end

  // Sticky error flags. A clear and a new error on the same edge leave the
  // new error set.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_reg <= 2'b00;
    end else begin
      err_reg <= (err_clr ? 2'b00 : err_reg) | {long_err, short_err};
    end
  end

  assign s_ready = s_ready_int;
  assign m_data  = m_data_reg;
  assign m_valid = m_valid_reg;
  assign m_last  = m_last_reg;
  assign err     = err_reg;

endmodule

// File: tb/tb_matrix_row_packer.sv
// ---------------------------------------------------------------------------
// tb_matrix_row_packer
//
// Directed bench for matrix_row_packer (PAD_BYTE = 8'hEE). Inputs are driven
// 1 time unit after the rising edge; outputs are sampled on the falling edge.
// A monitor queues every accepted row word; each test then compares the
// queued words against hand-computed expected values.
// ---------------------------------------------------------------------------
module tb_matrix_row_packer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_last;
  logic        s_ready;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;
  logic [1:0]  err;
  logic        err_clr;

  int checks = 0;
  int errors = 0;

  logic [32:0] mon_q [$];
  logic        fr_bp;

  always #5 clk = ~clk;

  matrix_row_packer #(
    .PAD_BYTE(8'hEE)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_last  (s_last),
    .s_ready (s_ready),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_last  (m_last),
    .err     (err),
    .err_clr (err_clr)
  );

  task automatic check_val(input string tag, input logic [63:0] got,
                           input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Output monitor: one line per accepted row word.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && m_valid && m_ready) begin
        mon_q.push_back({m_last, m_data});
        $display("word %08h last=%0b", m_data, m_last);
      end
    end
  end

  // Offer one byte until accepted; returns s_ready as first seen.
  task automatic send_byte(input logic [7:0] d, input logic l, input logic c,
                           output logic first_rdy);
    int waited;
    s_data  = d;
    s_valid = 1'b1;
    s_last  = l;
    err_clr = c;
    waited  = 0;
    @(negedge clk);
    first_rdy = s_ready;
    while (!s_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!s_ready) check_val("send_timeout", s_ready, 1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
    err_clr = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] base, input int n,
                            input logic with_last);
    logic fr;
    @(posedge clk);
    #1;
    for (int i = 0; i < n; i++) begin
      send_byte(base + 8'(i), with_last && (i == n - 1), 1'b0, fr);
    end
  endtask

  task automatic expect_frame(input string tag, input logic [31:0] w0,
                              input logic [31:0] w1, input logic [31:0] w2,
                              input logic [31:0] w3);
    logic [31:0] exp_w [4];
    logic [32:0] got;
    int t;
    exp_w = '{w0, w1, w2, w3};
    t = 0;
    while (mon_q.size() < 4 && t < 80) begin
      @(negedge clk);
      t++;
    end
    if (mon_q.size() < 4) check_val({tag, "_count"}, mon_q.size(), 4);
    for (int k = 0; k < 4; k++) begin
      if (mon_q.size() > 0) begin
        got = mon_q.pop_front();
        check_val({tag, "_data"}, got[31:0], exp_w[k]);
        check_val({tag, "_last"}, got[32], (k == 3));
      end
    end
  endtask

  task automatic idle_check(input string tag);
    repeat (6) @(negedge clk);
    check_val({tag, "_no_extra"}, mon_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    logic fr;
    rst_n   = 1'b0;
    s_data  = 8'h00;
    s_valid = 1'b0;
    s_last  = 1'b0;
    m_ready = 1'b1;
    err_clr = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_m_valid", m_valid, 0);
    check_val("rst_m_data", m_data, 32'h0);
    check_val("rst_m_last", m_last, 0);
    check_val("rst_err", err, 2'b00);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Nominal frame
    send_frame(8'h00, 16, 1'b1);
    expect_frame("nom", 32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C);
    check_val("nom_err", err, 2'b00);
    idle_check("nom");

    // Backpressure: m_ready low for 8 edges starting with the 4th
    @(posedge clk);
    #1;
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          send_byte(8'(i), (i == 15), 1'b0, fr_bp);
          if (i == 7) check_val("bp_sready_b7", fr_bp, 0);
        end
      end
      begin
        repeat (3) @(posedge clk);
        #1 m_ready = 1'b0;
        for (int j = 0; j < 8; j++) begin
          @(negedge clk);
          if (j > 0) begin
            check_val("bp_hold_data", m_data, 32'h03020100);
            check_val("bp_hold_valid", m_valid, 1);
          end
        end
        @(posedge clk);
        #1 m_ready = 1'b1;
      end
    join
    expect_frame("bp", 32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C);
    check_val("bp_err", err, 2'b00);
    idle_check("bp");

    // Short frame ending in word 1, padded out to four words
    send_frame(8'h10, 6, 1'b1);
    @(negedge clk);
    check_val("pad_sready0", s_ready, 0);
    @(negedge clk);
    check_val("pad_sready1", s_ready, 0);
    expect_frame("short", 32'h13121110, 32'hEEEE1514, 32'hEEEEEEEE, 32'hEEEEEEEE);
    check_val("short_err", err, 2'b01);
    idle_check("short");
    @(posedge clk);
    #1 err_clr = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;
    @(negedge clk);
    check_val("clr_err", err, 2'b00);

    // Short frame ending inside word 3: no pad words, m_last on the short word
    send_frame(8'h40, 14, 1'b1);
    expect_frame("short3", 32'h43424140, 32'h47464544, 32'h4B4A4948, 32'hEEEE4D4C);
    check_val("short3_err", err, 2'b01);
    idle_check("short3");
    @(posedge clk);
    #1 err_clr = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;

    // Long frame then a nominal frame
    send_frame(8'h50, 16, 1'b0);
    send_frame(8'h00, 16, 1'b1);
    expect_frame("long", 32'h53525150, 32'h57565554, 32'h5B5A5958, 32'h5F5E5D5C);
    expect_frame("recov", 32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C);
    check_val("long_err", err, 2'b10);
    idle_check("long");

    // err_clr on the same edge as a new short-frame error (1-byte frame)
    @(posedge clk);
    #1;
    send_byte(8'h30, 1'b1, 1'b1, fr);
    expect_frame("one", 32'hEEEEEE30, 32'hEEEEEEEE, 32'hEEEEEEEE, 32'hEEEEEEEE);
    check_val("clr_vs_set_err", err, 2'b01);
    idle_check("one");

    // Reset mid-frame, then a nominal frame
    send_frame(8'h20, 6, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_val("mid_rst_m_valid", m_valid, 0);
    check_val("mid_rst_m_data", m_data, 32'h0);
    check_val("mid_rst_m_last", m_last, 0);
    check_val("mid_rst_err", err, 2'b00);
    @(posedge clk);
    #1 rst_n = 1'b1;
    mon_q.delete();
    send_frame(8'h00, 16, 1'b1);
    expect_frame("post_rst", 32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C);
    check_val("post_rst_err", err, 2'b00);
    idle_check("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
